// File: rtl/uart_rx_sink_if.sv
// Byte output port of uart_rx_sink: first-word fall-through data with a valid/ready handshake.
// The sink drives the master side; the monitor or checker takes the slave side.
interface uart_rx_sink_if;
    logic [7:0] DOUT;
    logic       DOUT_VALID;
    logic       DOUT_READY;

    modport master (output DOUT, output DOUT_VALID, input DOUT_READY);
    modport slave  (input DOUT, input DOUT_VALID, output DOUT_READY);
endinterface

// File: rtl/uart_rx_sink.sv
// 8N1 UART frame decoder with a programmable bit period, feeding a byte FIFO
// that presents its head through a valid/ready port with sticky error flags.
module uart_rx_sink #(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [DIV_W-1:0]              BAUD_DIV,
    input  logic                          RXD,
    uart_rx_sink_if.master                dout,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_CNT,
    output logic                          FRAME_ERR,
    output logic                          OVERFLOW,
    input  logic                          CLR_ERR
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_e;

    state_e            state_q, state_d;
    logic              sync1_q, rx_s_q, rx_prev_q;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DIV_W-1:0]  tmr_q, tmr_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              frame_err_q, frame_err_d, overflow_q, overflow_d;
    logic [7:0]        mem_q [FIFO_DEPTH];

    logic [DIV_W-1:0]  d_eff;
    logic              tick, push, push_ok, pop, full, set_fe, set_ovf;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        tmr_d   = tmr_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        push    = 1'b0;
        set_fe  = 1'b0;
        d_eff   = (BAUD_DIV < DIV_W'(4)) ? DIV_W'(4) : BAUD_DIV;
        tick    = (tmr_q == '0);

        case (state_q)
            IDLE: begin
                if (rx_prev_q && !rx_s_q) begin
                    div_d   = d_eff;
                    tmr_d   = (d_eff >> 1) - DIV_W'(1);
                    bit_d   = 3'd0;
                    state_d = START;
                end
            end
            START: begin
                if (!tick) begin
                    tmr_d = tmr_q - DIV_W'(1);
                end else if (!rx_s_q) begin
                    tmr_d   = div_q - DIV_W'(1);
                    state_d = DATA;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (!tick) begin
                    tmr_d = tmr_q - DIV_W'(1);
                end else begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    tmr_d   = div_q - DIV_W'(1);
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (!tick) begin
                    tmr_d = tmr_q - DIV_W'(1);
                end else if (rx_s_q) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end else begin
                    set_fe  = 1'b1;
                    state_d = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A push into a full FIFO is only accepted when a pop frees a slot in the same cycle.
        pop      = (cnt_q != '0) && dout.DOUT_READY;
        full     = (cnt_q == CW'(FIFO_DEPTH));
        push_ok  = push && (!full || pop);
        set_ovf  = push && full && !pop;
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q + CW'(push_ok) - CW'(pop);

        frame_err_d = set_fe  || (frame_err_q && !CLR_ERR);
        overflow_d  = set_ovf || (overflow_q  && !CLR_ERR);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_prev_q   <= 1'b1;
            div_q       <= DIV_W'(4);
            tmr_q       <= '0;
            bit_q       <= 3'd0;
            shift_q     <= 8'h00;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= RXD;
            rx_s_q      <= sync1_q;
            rx_prev_q   <= rx_s_q;
            div_q       <= div_d;
            tmr_q       <= tmr_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    // NOTE: storage is deliberately not reset; the count alone decides which entries are live.
    always_ff @(posedge CLK) begin
        if (push_ok && !RST) mem_q[wr_ptr_q] <= shift_q;
    end

    assign dout.DOUT_VALID = (cnt_q != '0);
    assign dout.DOUT       = (cnt_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
    assign FIFO_CNT        = cnt_q;
    assign FRAME_ERR       = frame_err_q;
    assign OVERFLOW        = overflow_q;
endmodule

// File: tb/tb_uart_rx_sink.sv
// Directed bench for uart_rx_sink: drives bit-aligned 8N1 frames on RXD and checks
// the FIFO port, occupancy and sticky flags against hand-computed values.
module tb_uart_rx_sink;
    logic        clk;
    logic        rst;
    logic [15:0] baud_div;
    logic        rxd;
    logic [4:0]  fifo_cnt;
    logic        frame_err;
    logic        overflow;
    logic        clr_err;

    int checks   = 0;
    int failures = 0;
    int valid_cycles = 0;
    logic [7:0] popped[$];

    uart_rx_sink_if bus();

    uart_rx_sink #(.FIFO_DEPTH(16), .DIV_W(16)) dut (
        .CLK      (clk),
        .RST      (rst),
        .BAUD_DIV (baud_div),
        .RXD      (rxd),
        .dout     (bus),
        .FIFO_CNT (fifo_cnt),
        .FRAME_ERR(frame_err),
        .OVERFLOW (overflow),
        .CLR_ERR  (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.DOUT_VALID === 1'b1) valid_cycles++;
        if (bus.DOUT_VALID === 1'b1 && bus.DOUT_READY === 1'b1) popped.push_back(bus.DOUT);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int d);
        rxd = 1'b0;
        wait_cycles(d);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            wait_cycles(d);
        end
        rxd = stop_bit;
        wait_cycles(d);
        rxd = 1'b1;
    endtask

    task automatic do_pop();
        bus.DOUT_READY = 1'b1;
        wait_cycles(1);
        bus.DOUT_READY = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rxd = 1'b1; clr_err = 1'b0; baud_div = 16'd16; bus.DOUT_READY = 1'b0;
        wait_cycles(3);
        checks++; if (bus.DOUT_VALID !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", bus.DOUT_VALID); end
        checks++; if (fifo_cnt !== 5'd0) begin failures++; $display("FAIL reset_cnt: got %0d expected 0", fifo_cnt); end
        checks++; if (bus.DOUT !== 8'h00) begin failures++; $display("FAIL reset_dout: got %h expected 00", bus.DOUT); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        rst = 1'b0;
        wait_cycles(4);
    endtask

    task automatic test_single_byte();
        baud_div = 16'd16;
        bus.DOUT_READY = 1'b1;
        valid_cycles = 0;
        popped.delete();
        send_frame(8'hA5, 1'b1, 16);
        wait_cycles(10);
        bus.DOUT_READY = 1'b0;
        checks++; if (valid_cycles !== 1) begin failures++; $display("FAIL single_valid_cycles: got %0d expected 1", valid_cycles); end
        checks++; if (popped.size() !== 1) begin failures++; $display("FAIL single_pop_count: got %0d expected 1", popped.size()); end
        else begin
            checks++; if (popped[0] !== 8'hA5) begin failures++; $display("FAIL single_data: got %h expected a5", popped[0]); end
        end
        checks++; if (fifo_cnt !== 5'd0) begin failures++; $display("FAIL single_cnt: got %0d expected 0", fifo_cnt); end
        checks++; if (frame_err !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL single_flags: got fe=%b ovf=%b expected 0 0", frame_err, overflow); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_bytes [3];
        exp_bytes[0] = 8'h00; exp_bytes[1] = 8'hFF; exp_bytes[2] = 8'h55;
        baud_div = 16'd347;
        bus.DOUT_READY = 1'b0;
        for (int i = 0; i < 3; i++) send_frame(exp_bytes[i], 1'b1, 347);
        wait_cycles(5);
        checks++; if (fifo_cnt !== 5'd3) begin failures++; $display("FAIL b2b_cnt: got %0d expected 3", fifo_cnt); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.DOUT_VALID !== 1'b1 || bus.DOUT !== exp_bytes[i]) begin
                failures++; $display("FAIL b2b_pop%0d: got valid=%b data=%h expected 1 %h", i, bus.DOUT_VALID, bus.DOUT, exp_bytes[i]);
            end
            do_pop();
        end
        checks++; if (fifo_cnt !== 5'd0 || bus.DOUT_VALID !== 1'b0) begin failures++; $display("FAIL b2b_drained: got cnt=%0d valid=%b expected 0 0", fifo_cnt, bus.DOUT_VALID); end
    endtask

    task automatic test_false_start();
        baud_div = 16'd16;
        rxd = 1'b0;
        wait_cycles(5);
        rxd = 1'b1;
        wait_cycles(30);
        checks++; if (fifo_cnt !== 5'd0 || frame_err !== 1'b0) begin failures++; $display("FAIL false_start_quiet: got cnt=%0d fe=%b expected 0 0", fifo_cnt, frame_err); end
        send_frame(8'h3C, 1'b1, 16);
        wait_cycles(4);
        checks++; if (fifo_cnt !== 5'd1 || bus.DOUT !== 8'h3C) begin failures++; $display("FAIL false_start_next: got cnt=%0d data=%h expected 1 3c", fifo_cnt, bus.DOUT); end
        do_pop();
    endtask

    task automatic test_frame_error();
        baud_div = 16'd8;
        send_frame(8'h12, 1'b0, 8);
        rxd = 1'b0;
        wait_cycles(40);
        rxd = 1'b1;
        wait_cycles(5);
        checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL ferr_set: got %b expected 1", frame_err); end
        checks++; if (fifo_cnt !== 5'd0) begin failures++; $display("FAIL ferr_discard: got cnt=%0d expected 0", fifo_cnt); end
        send_frame(8'h34, 1'b1, 8);
        wait_cycles(4);
        checks++; if (fifo_cnt !== 5'd1 || bus.DOUT !== 8'h34) begin failures++; $display("FAIL ferr_next: got cnt=%0d data=%h expected 1 34", fifo_cnt, bus.DOUT); end
        checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL ferr_sticky: got %b expected 1", frame_err); end
        do_pop();
        clr_err = 1'b1;
        wait_cycles(1);
        clr_err = 1'b0;
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL ferr_clear: got %b expected 0", frame_err); end
    endtask

    task automatic test_overflow();
        baud_div = 16'd8;
        bus.DOUT_READY = 1'b0;
        for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1, 8);
        wait_cycles(4);
        checks++; if (fifo_cnt !== 5'd16) begin failures++; $display("FAIL ovf_cnt: got %0d expected 16", fifo_cnt); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set: got %b expected 1", overflow); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (bus.DOUT !== 8'(i)) begin failures++; $display("FAIL ovf_pop%0d: got %h expected %h", i, bus.DOUT, 8'(i)); end
            do_pop();
        end
        checks++; if (fifo_cnt !== 5'd0 || bus.DOUT_VALID !== 1'b0) begin failures++; $display("FAIL ovf_drained: got cnt=%0d valid=%b expected 0 0", fifo_cnt, bus.DOUT_VALID); end
        clr_err = 1'b1;
        wait_cycles(1);
        clr_err = 1'b0;
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear: got %b expected 0", overflow); end

        // Refill, then pop exactly on the edge where the 17th byte is written (detect+2, stop at 4+9*8).
        for (int i = 0; i < 16; i++) send_frame(8'h20 + 8'(i), 1'b1, 8);
        wait_cycles(4);
        popped.delete();
        fork
            send_frame(8'h99, 1'b1, 8);
            begin
                wait_cycles(78);
                bus.DOUT_READY = 1'b1;
                wait_cycles(1);
                bus.DOUT_READY = 1'b0;
            end
        join
        wait_cycles(4);
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL full_pop_no_ovf: got %b expected 0", overflow); end
        checks++; if (fifo_cnt !== 5'd16) begin failures++; $display("FAIL full_pop_cnt: got %0d expected 16", fifo_cnt); end
        checks++; if (popped.size() !== 1 || popped[0] !== 8'h20) begin failures++; $display("FAIL full_pop_head: got n=%0d expected 1 pop of 20", popped.size()); end
        for (int i = 1; i <= 16; i++) begin
            logic [7:0] exp_b;
            exp_b = (i == 16) ? 8'h99 : 8'h20 + 8'(i);
            checks++;
            if (bus.DOUT !== exp_b) begin failures++; $display("FAIL full_pop_drain%0d: got %h expected %h", i, bus.DOUT, exp_b); end
            do_pop();
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        baud_div = 16'd16;
        bus.DOUT_READY = 1'b0;
        send_frame(8'h5A, 1'b1, 16);
        wait_cycles(4);
        checks++; if (fifo_cnt !== 5'd1) begin failures++; $display("FAIL rmf_preload: got cnt=%0d expected 1", fifo_cnt); end
        b = 8'hC3;
        rxd = 1'b0;
        wait_cycles(16);
        for (int i = 0; i < 4; i++) begin
            rxd = b[i];
            wait_cycles(16);
        end
        rxd = b[4];
        wait_cycles(8);
        rst = 1'b1;
        rxd = 1'b1;
        wait_cycles(1);
        checks++; if (bus.DOUT_VALID !== 1'b0 || fifo_cnt !== 5'd0) begin failures++; $display("FAIL rmf_in_reset: got valid=%b cnt=%0d expected 0 0", bus.DOUT_VALID, fifo_cnt); end
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(200);
        checks++; if (fifo_cnt !== 5'd0 || frame_err !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL rmf_after: got cnt=%0d fe=%b ovf=%b expected 0 0 0", fifo_cnt, frame_err, overflow); end
        send_frame(8'h81, 1'b1, 16);
        wait_cycles(4);
        checks++; if (fifo_cnt !== 5'd1 || bus.DOUT !== 8'h81) begin failures++; $display("FAIL rmf_next: got cnt=%0d data=%h expected 1 81", fifo_cnt, bus.DOUT); end
        do_pop();
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_false_start();
        test_frame_error();
        test_overflow();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
